// File: rtl/lcd_ctrl.sv
// Write-only HD44780-style LCD bus controller: converts each STB rising edge in the
// core's LCD register into one timed setup / EN pulse / hold / execution-wait transaction.
module lcd_ctrl #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_drop
);

    localparam int CW = $clog2(T_EXEC_LONG + 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            stb_q;
    logic            long_r, long_s;
    logic            rs_r, rs_s;
    logic [7:0]      data_r, data_s;
    logic            en_r, busy_r, drop_r, on_r;
    logic            drop_s;
    logic            req_s;
    logic            cnt_done_s;
    logic            unused_s;

    assign req_s      = i_lcd_reg[10] & ~stb_q;
    assign cnt_done_s = (cnt_r == CNT_ZERO);
    assign unused_s   = ^{i_lcd_reg[30:11], i_lcd_reg[8]};

    // Next-state, counter and latched-field logic for the bus transaction FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        long_s  = long_r;
        rs_s    = rs_r;
        data_s  = data_r;
        drop_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_s) begin
                    rs_s    = i_lcd_reg[9];
                    data_s  = i_lcd_reg[7:0];
                    // Clear (0x01) and home (0x02/0x03) need the long execution wait
                    long_s  = ~i_lcd_reg[9] & (i_lcd_reg[7:2] == 6'd0) & (i_lcd_reg[7:0] != 8'd0);
                    cnt_s   = LD_SETUP;
                    state_s = S_SETUP;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            S_SETUP: begin
                if (cnt_done_s) begin
                    cnt_s   = LD_PULSE;
                    state_s = S_PULSE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_done_s) begin
                    cnt_s   = LD_HOLD;
                    state_s = S_HOLD;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_done_s) begin
                    cnt_s   = long_r ? LD_LONG : LD_EXEC;
                    state_s = S_EXEC;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            S_EXEC: begin
                if (cnt_done_s) begin
                    state_s = S_IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        // A request is only honoured in IDLE; anything else is reported and discarded
        if (req_s && (state_r != S_IDLE)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // State, counter and registered pin outputs; outputs are derived from next state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            stb_q   <= 1'b0;
            long_r  <= 1'b0;
            rs_r    <= 1'b0;
            data_r  <= 8'h00;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            drop_r  <= 1'b0;
            on_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            stb_q   <= i_lcd_reg[10];
            long_r  <= long_s;
            rs_r    <= rs_s;
            data_r  <= data_s;
            en_r    <= (state_s == S_PULSE);
            busy_r  <= (state_s != S_IDLE);
            drop_r  <= drop_s;
            on_r    <= i_lcd_reg[31];
        end
    end

    assign o_lcd_on   = on_r;
    assign o_lcd_en   = en_r;
    assign o_lcd_rs   = rs_r;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_r;
    assign o_busy     = busy_r;
    assign o_drop     = drop_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl; execution waits are shortened so the
// long-command cases finish quickly while keeping the default setup/pulse/hold.
module tb_lcd_ctrl;

    localparam int TS   = 2;
    localparam int TP   = 12;
    localparam int TH   = 2;
    localparam int TE   = 40;
    localparam int TEL  = 300;
    localparam int NORM = TS + TP + TH + TE;
    localparam int LONG = TS + TP + TH + TEL;
    localparam int LIMIT = LONG + 50;

    logic        clk;
    logic        rst_n;
    logic [31:0] lcd_reg;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, drop;
    logic [7:0]  lcd_data;

    int n_tests = 0;
    int n_fail  = 0;

    lcd_ctrl #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TEL)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_lcd_reg(lcd_reg),
        .o_lcd_on(lcd_on),
        .o_lcd_en(lcd_en),
        .o_lcd_rs(lcd_rs),
        .o_lcd_rw(lcd_rw),
        .o_lcd_data(lcd_data),
        .o_busy(busy),
        .o_drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // STB low then high with the given RS/DATA; returns one cycle after the accepting edge
    task automatic request(input logic rs, input logic [7:0] d);
        lcd_reg = 32'h0000_0000;
        lcd_reg[9] = rs;
        lcd_reg[7:0] = d;
        step();
        lcd_reg[10] = 1'b1;
        step();
    endtask

    // Walks the busy window, optionally rewriting the register at two cycle indices
    task automatic run(input logic [31:0] lo_val, input logic [31:0] hi_val,
                       input int lo_at, input int hi_at,
                       output int len, output int en_at, output int en_w,
                       output int drops, output int drop_at);
        len = 0; en_at = -1; en_w = 0; drops = 0; drop_at = -1;
        while (busy && len < LIMIT) begin
            if (lcd_en) begin
                if (en_at < 0) en_at = len;
                en_w++;
            end
            if (drop) begin
                if (drop_at < 0) drop_at = len;
                drops++;
            end
            if (lo_at == len) lcd_reg = lo_val;
            if (hi_at == len) lcd_reg = hi_val;
            len++;
            step();
        end
    endtask

    int len, en_at, en_w, drops, drop_at;

    initial begin
        rst_n   = 1'b0;
        lcd_reg = 32'h8000_07FF;
        repeat (3) step();
        check("rst_on",   {31'd0, lcd_on}, 32'd0);
        check("rst_en",   {31'd0, lcd_en}, 32'd0);
        check("rst_rs",   {31'd0, lcd_rs}, 32'd0);
        check("rst_rw",   {31'd0, lcd_rw}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);

        // Release with STB already high: accepted on first clock
        rst_n = 1'b1;
        step();
        check("rel_busy", {31'd0, busy}, 32'd1);
        check("rel_rs",   {31'd0, lcd_rs}, 32'd1);
        check("rel_data", {24'd0, lcd_data}, 32'hFF);
        check("rel_on",   {31'd0, lcd_on}, 32'd1);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("rel_len", len, NORM);
        check("rel_en_at", en_at, TS);
        check("rel_en_w", en_w, TP);

        // STB held high in IDLE must not start another transaction
        repeat (3) step();
        check("held_busy", {31'd0, busy}, 32'd0);
        check("held_drop", {31'd0, drop}, 32'd0);

        // Normal data write 'A'
        request(1'b1, 8'h41);
        check("a_busy", {31'd0, busy}, 32'd1);
        check("a_data", {24'd0, lcd_data}, 32'h41);
        check("a_rs",   {31'd0, lcd_rs}, 32'd1);
        check("a_on",   {31'd0, lcd_on}, 32'd0);
        check("a_rw",   {31'd0, lcd_rw}, 32'd0);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("a_len", len, NORM);
        check("a_en_at", en_at, TS);
        check("a_en_w", en_w, TP);

        // Long/normal command classification
        request(1'b0, 8'h01);
        check("clr_rs", {31'd0, lcd_rs}, 32'd0);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("clr_len", len, LONG);
        request(1'b0, 8'h02);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("home_len", len, LONG);
        request(1'b0, 8'h00);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("nop_len", len, NORM);
        request(1'b0, 8'h38);
        check("fs_data", {24'd0, lcd_data}, 32'h38);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("fs_len", len, NORM);
        // RS=1 with 0x01 is data, not a clear
        request(1'b1, 8'h01);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("d01_len", len, NORM);

        // Request mid-PULSE with 0x55 is dropped
        request(1'b1, 8'h33);
        run(32'h0000_0255, 32'h0000_0655, 4, 5, len, en_at, en_w, drops, drop_at);
        check("drp_count", drops, 1);
        check("drp_at", drop_at, 6);
        check("drp_en_w", en_w, TP);
        check("drp_len", len, NORM);
        check("drp_data", {24'd0, lcd_data}, 32'h33);
        check("drp_rs", {31'd0, lcd_rs}, 32'd1);

        // Asynchronous reset during PULSE
        request(1'b1, 8'h5A);
        for (int i = 0; i < 10 && !lcd_en; i++) step();
        check("mid_en_pre", {31'd0, lcd_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_en",   {31'd0, lcd_en}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_data", {24'd0, lcd_data}, 32'h00);
        lcd_reg = 32'h0000_0000;
        step();
        rst_n = 1'b1;
        request(1'b1, 8'h42);
        check("post_data", {24'd0, lcd_data}, 32'h42);
        run(32'd0, 32'd0, -1, -1, len, en_at, en_w, drops, drop_at);
        check("post_len", len, NORM);
        check("post_en_w", en_w, TP);

        // Request sampled on the EXEC-to-IDLE edge is dropped
        request(1'b1, 8'h61);
        run(32'h0000_0262, 32'h0000_0662, NORM - 2, NORM - 1, len, en_at, en_w, drops, drop_at);
        check("b2b_len", len, NORM);
        check("b2b_drop", {31'd0, drop}, 32'd1);
        check("b2b_busy", {31'd0, busy}, 32'd0);
        check("b2b_data", {24'd0, lcd_data}, 32'h61);
        step();
        check("b2b_drop_end", {31'd0, drop}, 32'd0);

        // Request in the first IDLE cycle is accepted
        request(1'b1, 8'h63);
        run(32'h0000_0264, 32'd0, NORM - 1, -1, len, en_at, en_w, drops, drop_at);
        check("acc_len", len, NORM);
        lcd_reg = 32'h0000_0664;
        step();
        check("acc_busy", {31'd0, busy}, 32'd1);
        check("acc_data", {24'd0, lcd_data}, 32'h64);
        check("acc_drop", {31'd0, drop}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Write-only HD44780-style character-LCD interface controller that sits directly downstream of the single-cycle core's `o_io_lcd` register. Software writes a command/data byte plus a strobe bit into the LCD register. This block turns each strobe into one correctly timed bus transaction: address setup, EN pulse, hold, then execution wait. It drives the physical LCD pins and reports `o_busy` so firmware can poll, for example via a spare switch-input bit.

## Interface
- `T_SETUP`, 2: cycles RS/DATA are stable before EN rises (>=1).
- `T_PULSE`, 12: cycles EN is held high (>=1).
- `T_HOLD`, 2: cycles RS/DATA are held after EN falls (>=1).
- `T_EXEC`, 2000: execution wait for normal commands and data (>=1). 40 us at 50 MHz.
- `T_EXEC_LONG`, 80000: execution wait for clear/home (>=1). 1.6 ms at 50 MHz.
- `i_clk`, in, 1: the one clock; all state changes on its rising edge.
- `i_reset`, in, 1: reset, asynchronous, active-low.
- `i_lcd_reg`, in, 32: LCD register from the core. Field layout:
  - [31] ON
  - [10] STB, a request on its 0->1 transition
  - [9] RS
  - [8] RW, ignored
  - [7:0] DATA
  - all other bits ignored
- `o_lcd_on`, out, 1: LCD power/backlight enable.
- `o_lcd_en`, out, 1: LCD enable strobe.
- `o_lcd_rs`, out, 1: register select; 0 = command, 1 = data.
- `o_lcd_rw`, out, 1: read/write; constant 0, writes only.
- `o_lcd_data`, out, 8: LCD data bus.
- `o_busy`, out, 1: a transaction is in progress.
- `o_drop`, out, 1: one-cycle pulse when a request arrives while busy.

## Operation
- **Strobe detect:**
  - `stb_q` registers `i_lcd_reg[10]` every cycle.
  - `req = i_lcd_reg[10] & ~stb_q`.
  - Holding STB high does not re-trigger; software must return it to 0 before the next request.
- **FSM states:** IDLE, SETUP, PULSE, HOLD, EXEC. A single down-counter of width `$clog2(T_EXEC_LONG+1)` times every state.
- **IDLE:**
  - On `req`, latch RS=`i_lcd_reg[9]` and DATA=`i_lcd_reg[7:0]` into the output registers.
  - Latch `long = ~RS & (DATA[7:2]==0) & (DATA!=0)`, which covers 0x01 clear and 0x02/0x03 home.
  - Load the counter with `T_SETUP-1` and go to SETUP.
- **SETUP:** when the counter reaches 0, load `T_PULSE-1` and go to PULSE.
- **PULSE:** `o_lcd_en`=1 throughout. When the counter reaches 0, load `T_HOLD-1` and go to HOLD.
- **HOLD:** when the counter reaches 0, load `long ? T_EXEC_LONG-1 : T_EXEC-1` and go to EXEC.
- **EXEC:** when the counter reaches 0, go to IDLE.
- **Outputs:**
  - `o_busy` = (state != IDLE).
  - `o_lcd_en` = (state == PULSE). All outputs are registered.
  - `o_lcd_rs` and `o_lcd_data` change only on acceptance; they keep the last transaction's value while idle.
- **ON bit:** `o_lcd_on` is a registered copy of `i_lcd_reg[31]`, updated every cycle and independent of the FSM.
- **Request while busy:**
  - `req` in any state other than IDLE is discarded. Latched fields do not change.
  - `o_drop` pulses high for exactly 1 cycle.
- **Back-to-back:** a request seen in the same cycle the FSM returns to IDLE (EXEC counter at 0) is dropped. A request in the first IDLE cycle is accepted.
- **Reset:** asserting `i_reset` low at any point, including mid-PULSE, forces immediately (asynchronous):
  - state = IDLE, counter = 0, `stb_q` = 0
  - `o_lcd_en` = 0, `o_lcd_rs` = 0, `o_lcd_data` = 0x00, `o_lcd_rw` = 0
  - `o_lcd_on` = 0, `o_busy` = 0, `o_drop` = 0
- **Reset release with STB already high:** this counts as a 0->1 edge on the first clock after release.

## Timing
- **Acceptance edge k:** from the cycle after edge k, `o_busy`=1 and `o_lcd_rs`/`o_lcd_data` hold the new values.
- **EN timing:** `o_lcd_en` rises `T_SETUP` cycles after `o_busy` rises and stays high for exactly `T_PULSE` cycles.
- **Busy duration:**
  - Normal: `T_SETUP+T_PULSE+T_HOLD+T_EXEC` cycles, 2016 at defaults.
  - Long: `T_SETUP+T_PULSE+T_HOLD+T_EXEC_LONG` cycles, 80016 at defaults.
- **`o_drop`:** asserted in the cycle after the edge where the dropped `req` was sampled.
- **`o_lcd_on`:** 1-cycle latency from `i_lcd_reg[31]`.
- **No combinational paths** from inputs to outputs.

## Test plan
- **Reset values:** hold `i_reset`=0 with `i_lcd_reg`=0x8000_07FF -> all outputs 0. Release -> next cycle `o_busy`=1, `o_lcd_rs`=1, `o_lcd_data`=0xFF, `o_lcd_on`=1.
- **Normal data write:** write 0x0000_0241, then 0x0000_0641 (STB rise, RS=1, 'A').
  - `o_lcd_data`=0x41, `o_lcd_rs`=1.
  - EN rises 2 cycles after `o_busy` and stays high 12 cycles.
  - `o_busy` lasts 2016 cycles.
- **Long command:** STB rise with RS=0, DATA=0x01 -> `o_busy` lasts 80016 cycles.
  - Repeat with 0x02 -> 80016.
  - Repeat with 0x00 and 0x38 -> 2016 each.
- **Request while busy:** issue a request mid-PULSE with DATA=0x55.
  - `o_drop` is a single 1-cycle pulse.
  - `o_lcd_data` keeps its original value; the EN pulse width is unchanged.
  - Also check: keeping STB high after IDLE produces no new transaction.
- **Reset mid-operation:** pull `i_reset` low during PULSE -> `o_lcd_en` and `o_busy` drop to 0 without waiting for a clock. After release, a new request completes normally in 2016 cycles.
- **Back-to-back:**
  - A request exactly at the EXEC-to-IDLE cycle -> dropped (`o_drop`=1).
  - A request one cycle later -> accepted.
